// File: rtl/freq_meas_scheduler.sv
// Round-robin scheduler that time-shares one frequency counter core across four input channels.
// Each grant runs SETTLE -> MEASURE -> REPORT, followed by an optional HOLD gap before the next grant.
module freq_meas_scheduler #(
  parameter int unsigned SETTLE_TICKS  = 1000,
  parameter int unsigned TIMEOUT_TICKS = 20_000_000,
  parameter int unsigned HOLD_TICKS    = 5_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  input  logic [3:0]  hold_units,
  input  logic        cnt_done,
  input  logic [31:0] cnt_value,
  output logic [1:0]  ch_sel,
  output logic        gate_en,
  output logic        result_valid,
  output logic [1:0]  result_ch,
  output logic [31:0] result_data,
  output logic        result_err,
  output logic        busy
);
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, REPORT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d, last_ch_q, last_ch_d, res_ch_q, res_ch_d, grant;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] tick_q, tick_d;
  logic [3:0]    unit_q, unit_d, units_q, units_d;
  logic [31:0]   res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic          tmo_hit, hold_end;

  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign hold_end = (tick_q == HOLD_LAST) && (unit_q == units_q - 4'd1);

  // First eligible channel above last_ch; descending loop so the nearest offset wins.
  always_comb begin
    grant = last_ch_q;
    for (int i = 4; i >= 1; i--) begin
      if (ch_mask[last_ch_q + 2'(i)]) grant = last_ch_q + 2'(i);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (ch_mask != 4'd0) state_d = SETTLE;
        SETTLE:  if (settle_q == SETTLE_LAST) state_d = MEASURE;
        MEASURE: if (cnt_done || tmo_hit) state_d = REPORT;
        REPORT:  state_d = (hold_units != 4'd0) ? HOLD : IDLE;
        HOLD:    if (hold_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ch_sel       = ch_q;
    gate_en      = (state_q == MEASURE);
    result_valid = (state_q == REPORT);
    busy         = (state_q != IDLE);
    result_ch    = res_ch_q;
    result_data  = res_data_q;
    result_err   = res_err_q;
  end

  // Counters default to zero so any exit, including an enable abort, leaves them clear.
  always_comb begin
    ch_d       = ch_q;
    last_ch_d  = last_ch_q;
    res_ch_d   = res_ch_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    units_d    = units_q;
    settle_d   = '0;
    tmo_d      = '0;
    tick_d     = '0;
    unit_d     = '0;
    if (enable) begin
      case (state_q)
        IDLE:   if (ch_mask != 4'd0) ch_d = grant;
        SETTLE: if (settle_q != SETTLE_LAST) settle_d = settle_q + SW'(1);
        MEASURE: begin
          if (cnt_done) begin
            res_data_d = cnt_value;
            res_err_d  = 1'b0;
            res_ch_d   = ch_q;
          end else if (tmo_hit) begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            res_ch_d   = ch_q;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        REPORT: begin
          last_ch_d = ch_q;
          units_d   = hold_units;
        end
        HOLD: begin
          if (tick_q != HOLD_LAST) begin
            tick_d = tick_q + HW'(1);
            unit_d = unit_q;
          end else if (!hold_end) begin
            unit_d = unit_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ch_q       <= 2'd0;
      last_ch_q  <= 2'd3;
      res_ch_q   <= 2'd0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      units_q    <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      tick_q     <= '0;
      unit_q     <= '0;
    end else begin
      ch_q       <= ch_d;
      last_ch_q  <= last_ch_d;
      res_ch_q   <= res_ch_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      units_q    <= units_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      tick_q     <= tick_d;
      unit_q     <= unit_d;
    end
  end
endmodule
